// File: rtl/bp_be_bserial_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
// Holds the opcode and FSM state encodings, plus small per-opcode helpers
// that the controller and the 1-bit slice both use.
package bp_be_bserial_pkg;

  localparam int unsigned bp_be_bserial_opcode_width = 4;

  typedef enum logic [3:0] {
    e_bserial_add   = 4'd0,
    e_bserial_sub   = 4'd1,
    e_bserial_xor   = 4'd2,
    e_bserial_and   = 4'd3,
    e_bserial_or    = 4'd4,
    e_bserial_passb = 4'd5,
    e_bserial_sll   = 4'd6,
    e_bserial_sext  = 4'd7,
    e_bserial_slt   = 4'd8,
    e_bserial_eq    = 4'd9,
    e_bserial_ne    = 4'd10
  } bp_be_bserial_opcode_e;

  typedef enum logic [1:0] {
    e_bserial_idle = 2'd0,
    e_bserial_run  = 2'd1,
    e_bserial_done = 2'd2
  } bp_be_bserial_state_e;

  // Ops whose result is a single flag zero-extended to the full width
  function automatic logic bserial_is_flag_op(input logic [3:0] op);
    return (op == e_bserial_slt) || (op == e_bserial_eq) || (op == e_bserial_ne);
  endfunction

  // Ops that subtract: carry starts at 1 and B is inverted
  function automatic logic bserial_is_sub_op(input logic [3:0] op);
    return (op == e_bserial_sub) || (op == e_bserial_slt);
  endfunction

endpackage

// File: rtl/bp_be_bserial_slice.sv
// One-bit ALU slice for the bit-serial sequencer (purely combinational).
// Ports:
//   op_i          opcode of the operation in flight
//   a_bit_i       current A bit (already gated for sll hold by the controller)
//   b_bit_i       current B bit
//   state_bit_i   carry (add/sub/slt) or sticky difference flag (eq/ne)
//   last_bit_i    high on the final (MSB) bit
//   r_bit_o       result bit for this position
//   state_bit_n_o state bit to carry into the next position
module bp_be_bserial_slice
  import bp_be_bserial_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic       a_bit_i,
  input  logic       b_bit_i,
  input  logic       state_bit_i,
  input  logic       last_bit_i,
  output logic       r_bit_o,
  output logic       state_bit_n_o
);

  logic b_eff;
  logic sum;
  logic cout;
  logic diff_seen;

  always_comb begin
    b_eff     = b_bit_i ^ bserial_is_sub_op(op_i);
    sum       = a_bit_i ^ b_eff ^ state_bit_i;
    cout      = (a_bit_i & b_eff) | (a_bit_i & state_bit_i) | (b_eff & state_bit_i);
    diff_seen = state_bit_i | (a_bit_i ^ b_bit_i);
  end

  always_comb begin
    r_bit_o       = 1'b0;
    state_bit_n_o = state_bit_i;
    case (op_i)
      e_bserial_add,
      e_bserial_sub: begin
        r_bit_o       = sum;
        state_bit_n_o = cout;
      end
      e_bserial_xor:   r_bit_o = a_bit_i ^ b_bit_i;
      e_bserial_and:   r_bit_o = a_bit_i & b_bit_i;
      e_bserial_or:    r_bit_o = a_bit_i | b_bit_i;
      e_bserial_passb: r_bit_o = b_bit_i;
      e_bserial_sll,
      e_bserial_sext:  r_bit_o = a_bit_i;
      e_bserial_slt: begin
        // signed less-than: sign of difference corrected by overflow (cin^cout at MSB)
        state_bit_n_o = cout;
        r_bit_o       = last_bit_i & (sum ^ state_bit_i ^ cout);
      end
      e_bserial_eq: begin
        state_bit_n_o = diff_seen;
        r_bit_o       = last_bit_i & ~diff_seen;
      end
      e_bserial_ne: begin
        state_bit_n_o = diff_seen;
        r_bit_o       = last_bit_i & diff_seen;
      end
      default: r_bit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/bp_be_bserial_ctrl.sv
// Bit-serial ALU sequencer. Accepts one op over ready/valid, streams the
// operands LSB-first through a 1-bit slice for width_p cycles, and returns
// the assembled result over valid/yumi.
// Ports:
//   clk_i, reset_i  clock, synchronous active-high reset
//   v_i / ready_o   request handshake; op_i, a_i, b_i request payload
//   v_o / yumi_i    result handshake; data_o result (registered)
module bp_be_bserial_ctrl
  import bp_be_bserial_pkg::*;
#(
  parameter int unsigned width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [3:0]         op_i,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int unsigned lg_width_lp = $clog2(width_p);

  bp_be_bserial_state_e     state_q, state_d;
  logic [lg_width_lp-1:0]   cnt_q, cnt_d;
  logic [lg_width_lp-1:0]   k_q, k_d;
  logic [3:0]               op_q, op_d;
  logic [width_p-1:0]       a_q, a_d;
  logic [width_p-1:0]       b_q, b_d;
  logic [width_p-1:0]       res_q, res_d;
  logic                     s_q, s_d;
  logic                     ready_q, ready_d;
  logic                     v_q, v_d;

  logic cnt_ge_k;
  logic last_bit;
  logic a_bit;
  logic r_bit;
  logic s_n;

  assign cnt_ge_k = (cnt_q >= k_q);
  assign last_bit = (cnt_q == lg_width_lp'(width_p - 1));
  // sll emits zeros below the shift amount
  assign a_bit    = ((op_q == e_bserial_sll) && !cnt_ge_k) ? 1'b0 : a_q[0];

  bp_be_bserial_slice slice (
    .op_i          (op_q),
    .a_bit_i       (a_bit),
    .b_bit_i       (b_q[0]),
    .state_bit_i   (s_q),
    .last_bit_i    (last_bit),
    .r_bit_o       (r_bit),
    .state_bit_n_o (s_n)
  );

  // Next-state, datapath and handshake logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    ready_d = ready_q;
    v_d     = v_q;

    case (state_q)
      e_bserial_idle: begin
        if (v_i && ready_q) begin
          op_d    = op_i;
          a_d     = a_i;
          b_d     = b_i;
          k_d     = b_i[lg_width_lp-1:0];
          cnt_d   = '0;
          s_d     = bserial_is_sub_op(op_i);
          ready_d = 1'b0;
          state_d = e_bserial_run;
        end
      end

      e_bserial_run: begin
        b_d = b_q >> 1;
        s_d = s_n;
        // sll holds A until the shift amount is reached; sext freezes A on bit k
        if (op_q == e_bserial_sll) begin
          if (cnt_ge_k) a_d = a_q >> 1;
        end else if (op_q == e_bserial_sext) begin
          if (cnt_q < k_q) a_d = a_q >> 1;
        end else begin
          a_d = a_q >> 1;
        end

        // Flag ops land their single result bit at position 0
        if (last_bit && bserial_is_flag_op(op_q)) begin
          res_d = width_p'(r_bit);
        end else begin
          res_d = {r_bit, res_q[width_p-1:1]};
        end

        if (last_bit) begin
          v_d     = 1'b1;
          state_d = e_bserial_done;
        end else begin
          cnt_d = cnt_q + lg_width_lp'(1);
        end
      end

      e_bserial_done: begin
        if (yumi_i) begin
          v_d     = 1'b0;
          ready_d = 1'b1;
          state_d = e_bserial_idle;
        end
      end

      default: begin
        v_d     = 1'b0;
        ready_d = 1'b1;
        state_d = e_bserial_idle;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_bserial_idle;
      cnt_q   <= '0;
      k_q     <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= 1'b0;
      ready_q <= 1'b1;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      ready_q <= ready_d;
      v_q     <= v_d;
    end
  end

  // Consumer must only take a result that is being offered
  always_ff @(posedge clk_i) begin
    if (!reset_i && yumi_i) begin
      assert (v_q);
    end
  end

  assign ready_o = ready_q;
  assign v_o     = v_q;
  assign data_o  = res_q;

endmodule

// File: tb/tb_bp_be_bserial_ctrl.sv
// Scoreboard bench for bp_be_bserial_ctrl at width_p=8.
module tb_bp_be_bserial_ctrl;
  import bp_be_bserial_pkg::*;

  localparam int unsigned W = 8;

  logic         clk_i;
  logic         reset_i = 1'b1;
  logic         v_i     = 1'b0;
  logic         ready_o;
  logic [3:0]   op_i    = '0;
  logic [W-1:0] a_i     = '0;
  logic [W-1:0] b_i     = '0;
  logic         v_o;
  logic [W-1:0] data_o;
  logic         yumi_i  = 1'b0;

  bp_be_bserial_ctrl #(.width_p(W)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (v_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .v_o     (v_o),
    .data_o  (data_o),
    .yumi_i  (yumi_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] data;
    int           acc;
    int           hold;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   vec = 0;
  int   errs = 0;
  int   cyc = 0;
  int   hold_cnt = 0;
  logic got = 1'b0;
  logic rdy_bad = 1'b0;
  logic stab_bad = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vec++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard when a result appears, then releases it with yumi
  always @(negedge clk_i) begin
    cyc++;
    if (yumi_i) begin
      yumi_i = 1'b0;
      got    = 1'b0;
    end else begin
      if ((exp_q.size() > 0 || got) && ready_o) rdy_bad = 1'b1;
      if (v_o && !got) begin
        got      = 1'b1;
        stab_bad = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(v_o), 32'd0);
          cur.data = data_o;
          cur.hold = 0;
          hold_cnt = 0;
        end else begin
          cur      = exp_q.pop_front();
          hold_cnt = cur.hold;
          check("data", 32'(data_o), 32'(cur.data));
          check("latency", 32'(cyc - cur.acc), 32'(W + 1));
        end
      end
      if (got) begin
        if (data_o !== cur.data) stab_bad = 1'b1;
        if (hold_cnt == 0) begin
          if (cur.hold > 0) check("data_stable", 32'(stab_bad), 32'd0);
          check("ready_low_while_busy", 32'(rdy_bad), 32'd0);
          rdy_bad = 1'b0;
          yumi_i  = 1'b1;
        end else begin
          hold_cnt--;
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] expv, input int hold, input bit push);
    int   n = 0;
    exp_t e;
    @(negedge clk_i);
    while (!ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) begin
      check("ready_timeout", 32'(ready_o), 32'd1);
      return;
    end
    op_i = op;
    a_i  = a;
    b_i  = b;
    v_i  = 1'b1;
    @(posedge clk_i);
    if (push) begin
      e.data = expv;
      e.acc  = cyc;
      e.hold = hold;
      exp_q.push_back(e);
    end
    @(negedge clk_i);
    v_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    check("reset_ready", 32'(ready_o), 32'd1);
    check("reset_v", 32'(v_o), 32'd0);
    check("reset_data", 32'(data_o), 32'd0);

    send(e_bserial_add,   8'h7F, 8'h01, 8'h80, 0, 1'b1);
    send(e_bserial_sub,   8'h05, 8'h07, 8'hFE, 0, 1'b1);
    send(e_bserial_slt,   8'h80, 8'h01, 8'h01, 0, 1'b1);
    send(e_bserial_slt,   8'h01, 8'h80, 8'h00, 0, 1'b1);
    send(e_bserial_sll,   8'h81, 8'h03, 8'h08, 0, 1'b1);
    send(e_bserial_sext,  8'h0C, 8'h03, 8'hFC, 0, 1'b1);
    send(e_bserial_sext,  8'h04, 8'h03, 8'h04, 0, 1'b1);
    send(e_bserial_eq,    8'h5A, 8'h5A, 8'h01, 0, 1'b1);
    send(e_bserial_ne,    8'h5A, 8'h5B, 8'h01, 0, 1'b1);
    send(e_bserial_and,   8'hF0, 8'h3C, 8'h30, 0, 1'b1);
    send(e_bserial_passb, 8'h33, 8'hA5, 8'hA5, 0, 1'b1);
    send(4'hF,            8'hFF, 8'hFF, 8'h00, 0, 1'b1);

    // Result held for 5 cycles while stray requests are offered
    send(e_bserial_xor, 8'hF0, 8'h3C, 8'hCC, 5, 1'b1);
    n = 0;
    while (!v_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("v_o_timeout", 32'(v_o), 32'd1);
    op_i = e_bserial_add;
    a_i  = 8'hFF;
    b_i  = 8'hFF;
    v_i  = 1'b1;
    repeat (3) @(negedge clk_i);
    v_i = 1'b0;
    send(e_bserial_or, 8'hF0, 8'h3C, 8'hFC, 0, 1'b1);

    // Reset in the middle of a run discards it
    send(e_bserial_add, 8'h11, 8'h22, 8'h00, 0, 1'b0);
    repeat (4) @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    check("abort_ready", 32'(ready_o), 32'd1);
    check("abort_v", 32'(v_o), 32'd0);
    check("abort_data", 32'(data_o), 32'd0);
    send(e_bserial_add, 8'h02, 8'h03, 8'h05, 0, 1'b1);

    n = 0;
    while ((exp_q.size() > 0 || got || yumi_i) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
